// File: rtl/cp0_timer_ctrl.sv
// cp0_timer_ctrl: coprocessor 0 with SR, Cause, EPC, PRId and a Count/Compare timer.
// Interrupt and exception requests are raised combinationally toward the NPC/flush
// logic. All architectural state updates at the next rising clock edge.
module cp0_timer_ctrl #(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h20030407,
  parameter bit          TIMER_EN  = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           rd_addr,
  input  logic [4:0]           wr_addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  input  logic [31:0]          vpc,
  input  logic                 bd_in,
  input  logic [4:0]           exc_code,
  input  logic [NUM_HWINT-1:0] hwint,
  input  logic                 eret,
  output logic [31:0]          epc_out,
  output logic                 req
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  logic [7:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [7:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;
  logic [31:0] count;
  logic [31:0] compare;
  logic        ti;

  logic [5:0]  hw_ip;
  logic        int_req;
  logic        exc_req;
  logic        wr_count;
  logic        wr_compare;
  logic        wr_sr;
  logic        wr_cause;
  logic        wr_epc;

  // Map hardware lines onto IP2..IP6; IP7 carries the timer, shared with hwint[5] when present.
  generate
    for (genvar i = 0; i < 5; i++) begin : g_ip
      if (i < NUM_HWINT) begin : g_used
        assign hw_ip[i] = hwint[i];
      end else begin : g_unused
        assign hw_ip[i] = 1'b0;
      end
    end
    if (NUM_HWINT == 6) begin : g_shared_ip7
      assign hw_ip[5] = ti | hwint[5];
    end else begin : g_timer_ip7
      assign hw_ip[5] = ti;
    end
  endgenerate

  assign wr_count   = we && (wr_addr == ADDR_COUNT);
  assign wr_compare = we && (wr_addr == ADDR_COMPARE);
  assign wr_sr      = we && (wr_addr == ADDR_SR);
  assign wr_cause   = we && (wr_addr == ADDR_CAUSE);
  assign wr_epc     = we && (wr_addr == ADDR_EPC);

  assign int_req = (|(cause_ip & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = |exc_code;
  assign req     = int_req | exc_req;
  assign epc_out = epc;

  // mfc0 read mux; returns the pre-edge value even when an mtc0 hits the same register.
  always_comb begin
    rdata = 32'h0;
    case (rd_addr)
      ADDR_COUNT:   rdata = count;
      ADDR_COMPARE: rdata = compare;
      ADDR_SR:      rdata = {16'h0, sr_im, 6'h0, sr_exl, sr_ie};
      ADDR_CAUSE:   rdata = {cause_bd, 15'h0, cause_ip, 1'b0, cause_exc, 2'b00};
      ADDR_EPC:     rdata = epc;
      ADDR_PRID:    rdata = PRID_VAL;
      default:      rdata = 32'h0;
    endcase
  end

  // Status register: a taken request sets EXL and blocks mtc0; eret beats an mtc0 on EXL only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_im  <= 8'h0;
      sr_exl <= 1'b0;
      sr_ie  <= 1'b0;
    end else if (req) begin
      sr_exl <= 1'b1;
    end else begin
      if (wr_sr) begin
        sr_im  <= wdata[15:8];
        sr_exl <= wdata[1];
        sr_ie  <= wdata[0];
      end
      if (eret) begin
        sr_exl <= 1'b0;
      end
    end
  end

  // Cause register: hardware pending bits track their sources every cycle; software bits via mtc0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cause_bd  <= 1'b0;
      cause_ip  <= 8'h0;
      cause_exc <= 5'h0;
    end else begin
      cause_ip[7:2] <= hw_ip;
      if (req) begin
        cause_bd  <= bd_in;
        cause_exc <= int_req ? 5'h0 : exc_code;
      end else if (wr_cause) begin
        cause_ip[1:0] <= wdata[9:8];
      end
    end
  end

  // EPC captures the restart address on a request, pointing at the branch for delay-slot faults.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      epc <= 32'h0;
    end else if (req) begin
      epc <= bd_in ? (vpc - 32'd4) : vpc;
    end else if (wr_epc) begin
      epc <= {wdata[31:2], 2'b00};
    end
  end

  // Count/Compare timer; TI is sticky on a match and only a Compare write clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= 32'h0;
      compare <= 32'hFFFF_FFFF;
      ti      <= 1'b0;
    end else begin
      if (wr_count) begin
        count <= wdata;
      end else if (TIMER_EN) begin
        count <= count + 32'd1;
      end
      if (wr_compare) begin
        compare <= wdata;
        ti      <= 1'b0;
      end else if (TIMER_EN && (count == compare)) begin
        ti <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp0_timer_ctrl.sv
// tb_cp0_timer_ctrl: directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a word-level reference model of coprocessor 0.
module tb_cp0_timer_ctrl;

  localparam logic [31:0] PRID = 32'h20030407;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        we = 1'b0;
  logic [4:0]  rd_addr = 5'd0;
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] vpc = 32'h0;
  logic        bd_in = 1'b0;
  logic [4:0]  exc_code = 5'd0;
  logic [5:0]  hwint = 6'h0;
  logic        eret = 1'b0;
  logic [31:0] rdata;
  logic [31:0] epc_out;
  logic        req;

  int compared = 0;
  int mismatched = 0;

  // Reference model state, stored as whole architectural register words
  logic [31:0] m_sr, m_cause, m_epc, m_count, m_compare;
  logic        m_ti;
  logic [31:0] n_sr, n_cause, n_epc, n_count, n_compare;
  logic        n_ti;
  logic        m_take, m_irq;

  // Random stimulus scratch
  logic        r_we, r_bd, r_eret;
  logic [4:0]  r_wa, r_ra, r_ec;
  logic [31:0] r_wd, r_pc;
  logic [5:0]  r_hw;
  logic [4:0]  wa_table [8];

  // Directed scratch
  logic        seen;
  logic [31:0] count_at_req;
  int          waited;
  logic [4:0]  rst_addr [7];
  logic [31:0] rst_val [7];

  always #5 clk = ~clk;

  cp0_timer_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .we       (we),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .vpc      (vpc),
    .bd_in    (bd_in),
    .exc_code (exc_code),
    .hwint    (hwint),
    .eret     (eret),
    .epc_out  (epc_out),
    .req      (req)
  );

  function automatic logic m_int_req();
    return ((m_cause[15:8] & m_sr[15:8]) != 8'h0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic m_req();
    return m_int_req() || (exc_code != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'h0;
    endcase
  endfunction

  // Model update: compute every next register word from the current words and inputs
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
      m_count = 32'h0; m_compare = 32'hFFFF_FFFF; m_ti = 1'b0;
    end else begin
      m_take = m_req();
      m_irq = m_int_req();
      n_sr = m_sr; n_cause = m_cause; n_epc = m_epc;
      n_count = m_count + 32'd1;
      n_compare = m_compare;
      n_ti = m_ti || (m_count == m_compare);
      if (we) begin
        case (wr_addr)
          5'd9:  n_count = wdata;
          5'd11: begin n_compare = wdata; n_ti = 1'b0; end
          5'd12: n_sr = wdata & 32'h0000_FF03;
          5'd13: n_cause = (m_cause & ~32'h300) | (wdata & 32'h300);
          5'd14: n_epc = wdata & 32'hFFFF_FFFC;
          default: ;
        endcase
      end
      if (eret) n_sr = n_sr & ~32'h2;
      if (m_take) begin
        n_sr = m_sr | 32'h2;
        n_cause = (m_cause & 32'h300) | {bd_in, 31'h0} |
                  (m_irq ? 32'h0 : {25'h0, exc_code, 2'b00});
        n_epc = bd_in ? (vpc - 32'd4) : vpc;
      end
      n_cause[15:10] = {m_ti | hwint[5], hwint[4:0]};
      m_sr = n_sr; m_cause = n_cause; m_epc = n_epc;
      m_count = n_count; m_compare = n_compare; m_ti = n_ti;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic [4:0] ra, input logic [4:0] ec, input logic [31:0] pc,
                               input logic bd, input logic er, input logic [5:0] hw);
    we = w; wr_addr = wa; wdata = wd; rd_addr = ra; exc_code = ec;
    vpc = pc; bd_in = bd; eret = er; hwint = hw;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic atSample();
    @(negedge clk);
  endtask

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    checkOutput("model_req", {31'h0, req}, {31'h0, m_req()});
    checkOutput("model_epc_out", epc_out, m_epc);
    checkOutput("model_rdata", rdata, m_read(rd_addr));
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    wa_table = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3, 5'd0};
    rst_addr = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    rst_val  = '{32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, PRID, 32'h0};

    // Power-on reset
    applyStimulus(0, 0, 0, 12, 0, 0, 0, 0, 0);
    #1 reset = 1'b0;
    #2;
    checkOutput("reset_sr", rdata, 32'h0);
    checkOutput("reset_req", {31'h0, req}, 32'h0);
    checkOutput("reset_epc_out", epc_out, 32'h0);
    rd_addr = 5'd11;
    #1 checkOutput("reset_compare", rdata, 32'hFFFF_FFFF);
    #13 reset = 1'b1;
    nextCycle();

    // Hardware interrupt on IP2
    applyStimulus(1, 12, 32'h401, 13, 0, 32'h100, 0, 0, 6'h01);
    nextCycle();
    applyStimulus(0, 0, 0, 13, 0, 32'h200, 0, 0, 6'h01);
    atSample();
    checkOutput("t1_req_taken", {31'h0, req}, 32'h1);
    checkOutput("t1_cause_ip2", rdata, 32'h400);
    nextCycle();
    applyStimulus(0, 0, 0, 12, 0, 32'h300, 0, 0, 6'h01);
    atSample();
    checkOutput("t1_req_masked_by_exl", {31'h0, req}, 32'h0);
    checkOutput("t1_sr_exl", rdata, 32'h403);
    nextCycle();
    applyStimulus(0, 0, 0, 14, 0, 0, 0, 1, 6'h00);
    atSample();
    checkOutput("t1_epc", rdata, 32'h200);
    nextCycle();
    applyStimulus(1, 12, 32'h0, 13, 0, 0, 0, 0, 6'h00);
    atSample();
    checkOutput("t1_req_after_eret", {31'h0, req}, 32'h0);
    checkOutput("t1_cause_cleared", rdata, 32'h0);
    nextCycle();

    // Exception in a delay slot
    applyStimulus(0, 0, 0, 13, 5'd4, 32'h3010, 1, 0, 0);
    atSample();
    checkOutput("t2_req", {31'h0, req}, 32'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 14, 0, 0, 0, 0, 0);
    atSample();
    checkOutput("t2_epc", rdata, 32'h300C);
    checkOutput("t2_epc_out", epc_out, 32'h300C);
    nextCycle();
    applyStimulus(0, 0, 0, 13, 0, 0, 0, 1, 0);
    atSample();
    checkOutput("t2_cause", rdata, 32'h8000_0010);
    nextCycle();

    // Timer interrupt through IP7
    applyStimulus(1, 9, 32'h0, 9, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 11, 32'd20, 9, 0, 0, 0, 0, 0);
    atSample();
    checkOutput("t3_count_loaded", rdata, 32'h0);
    nextCycle();
    applyStimulus(1, 12, 32'h8001, 9, 0, 0, 0, 0, 0);
    atSample();
    checkOutput("t3_count_next", rdata, 32'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 9, 0, 0, 0, 0, 0);
    seen = 1'b0;
    count_at_req = 32'h0;
    waited = 0;
    while (!seen && waited < 40) begin
      atSample();
      if (req) begin
        seen = 1'b1;
        count_at_req = rdata;
      end else begin
        nextCycle();
      end
      waited++;
    end
    checkOutput("t3_timer_req_seen", {31'h0, seen}, 32'h1);
    checkOutput("t3_count_at_req", count_at_req, 32'd22);
    nextCycle();
    applyStimulus(1, 11, 32'hFFFF_FFFF, 9, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 9, 0, 0, 0, 1, 0);
    nextCycle();
    applyStimulus(1, 12, 32'h0, 13, 0, 0, 0, 0, 0);
    atSample();
    checkOutput("t3_req_cleared", {31'h0, req}, 32'h0);
    checkOutput("t3_cause_after", rdata, 32'h0);
    nextCycle();

    // Count wrap and load-without-increment
    applyStimulus(1, 9, 32'hFFFF_FFFE, 9, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 0, 9, 0, 0, 0, 0, 0);
    atSample();
    checkOutput("t4_load", rdata, 32'hFFFF_FFFE);
    nextCycle();
    atSample();
    checkOutput("t4_max", rdata, 32'hFFFF_FFFF);
    nextCycle();
    atSample();
    checkOutput("t4_wrap", rdata, 32'h0);
    nextCycle();
    applyStimulus(1, 9, 32'h1234, 9, 0, 0, 0, 0, 0);
    atSample();
    checkOutput("t4_read_old_value", rdata, 32'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 9, 0, 0, 0, 0, 0);
    atSample();
    checkOutput("t4_load_no_inc", rdata, 32'h1234);
    nextCycle();
    atSample();
    checkOutput("t4_inc_after_load", rdata, 32'h1235);
    nextCycle();

    // Request beats eret and mtc0 SR; then a software interrupt
    applyStimulus(1, 11, 32'hFFFF_FFFF, 9, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 12, 32'h0, 12, 5'd8, 32'h4000, 0, 1, 0);
    atSample();
    checkOutput("t5_req", {31'h0, req}, 32'h1);
    nextCycle();
    applyStimulus(0, 0, 0, 12, 0, 0, 0, 0, 0);
    atSample();
    checkOutput("t5_exl_kept", rdata, 32'h2);
    nextCycle();
    applyStimulus(1, 13, 32'h100, 13, 0, 0, 0, 1, 0);
    atSample();
    checkOutput("t5_cause_exc", rdata, 32'h20);
    nextCycle();
    applyStimulus(1, 12, 32'h101, 13, 0, 0, 0, 0, 0);
    atSample();
    checkOutput("t5_no_req_ie_off", {31'h0, req}, 32'h0);
    checkOutput("t5_cause_sw", rdata, 32'h120);
    nextCycle();
    applyStimulus(0, 0, 0, 12, 0, 32'h5000, 0, 0, 0);
    atSample();
    checkOutput("t5_swint_req", {31'h0, req}, 32'h1);
    checkOutput("t5_sr", rdata, 32'h101);
    nextCycle();
    applyStimulus(1, 13, 32'h0, 13, 0, 0, 0, 0, 0);
    nextCycle();
    applyStimulus(1, 12, 32'h0, 12, 0, 0, 0, 1, 0);
    nextCycle();

    // Asynchronous reset in the middle of a cycle
    applyStimulus(0, 0, 0, 9, 0, 0, 0, 0, 0);
    #2 reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rd_addr = rst_addr[i];
      #1 checkOutput("t6_async_reset_read", rdata, rst_val[i]);
    end
    checkOutput("t6_epc_out", epc_out, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    nextCycle();

    // Randomized traffic
    r_hw = 6'h0;
    for (int c = 0; c < 2000; c++) begin
      r_we = ($urandom_range(0, 99) < 30);
      r_wa = wa_table[$urandom_range(0, 7)];
      r_wd = $urandom;
      if (r_wa == 5'd11 && $urandom_range(0, 1) == 1) r_wd = m_count + $urandom_range(1, 25);
      if (r_wa == 5'd12 && $urandom_range(0, 1) == 1) r_wd = r_wd & 32'hFFFF_FFFD;
      r_ra = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 15));
      r_ec = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      if ($urandom_range(0, 19) == 0) r_hw = 6'($urandom);
      r_eret = ($urandom_range(0, 9) == 0);
      r_bd = 1'($urandom);
      r_pc = $urandom;
      applyStimulus(r_we, r_wa, r_wd, r_ra, r_ec, r_pc, r_bd, r_eret, r_hw);
      nextCycle();
    end

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    nextCycle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
